// File: rtl/mutex_sched_if.sv
// Request/grant pair between mutex_sched and a two-way asynchronous mutex.
interface mutex_sched_if;
  logic req0;
  logic req1;
  logic grant0;
  logic grant1;

  // Scheduler side: drives requests, receives asynchronous grants
  modport master (
    output req0,
    output req1,
    input  grant0,
    input  grant1
  );

  // Mutex side: receives requests, drives grants
  modport slave (
    input  req0,
    input  req1,
    output grant0,
    output grant1
  );
endinterface

// File: rtl/mutex_sched.sv
// mutex_sched: programmable four-phase request generator and protocol checker
// for a two-way asynchronous mutex. Each channel runs IDLE/REQ/HOLD/REL/GAP;
// grants are synchronised, and overlap / spurious-grant / timeout violations
// latch a sticky error with the first error code.
// Optional build macro: MUTEX_SCHED_STATS_EN enables per-channel completion
// counters on cnt0/cnt1; without it they are tied to zero.
module mutex_sched #(
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned TMO    = 1023,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold0,
  input  logic [HOLD_W-1:0] hold1,
  input  logic [HOLD_W-1:0] gap,
  mutex_sched_if.master     mx,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam int unsigned TMR_W = (TMO < 1) ? 1 : $clog2(TMO + 1);

  localparam logic [1:0] E_OVL  = 2'b01;
  localparam logic [1:0] E_SPUR = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_REL,
    S_GAP
  } state_t;

  // Grant synchroniser stages
  logic [1:0] gsync_q;
  logic [1:0] gs_q;

  // Per-channel state
  state_t                  st_q [2];
  state_t                  st_d [2];
  logic [1:0][HOLD_W-1:0]  dly_q;
  logic [1:0][HOLD_W-1:0]  dly_d;
  logic [1:0][TMR_W-1:0]   tmr_q;
  logic [1:0][TMR_W-1:0]   tmr_d;
  logic [1:0]              req_q;
  logic [1:0]              req_d;
  logic [1:0]              done_q;
  logic [1:0]              done_d;

  // Shared state
  logic       turn_q;
  logic       turn_d;
  logic       ovl_q;
  logic       ovl_c;
  logic       err_q;
  logic       err_d;
  logic [1:0] code_q;
  logic [1:0] code_d;

  logic [1:0]             start_c;
  logic [1:0]             spur_c;
  logic [1:0]             tmo_c;
  logic [1:0][HOLD_W-1:0] hold_sel;

  // A zero hold is stretched to one cycle so HOLD always terminates
  assign hold_sel[0] = (hold0 == '0) ? HOLD_W'(1) : hold0;
  assign hold_sel[1] = (hold1 == '0) ? HOLD_W'(1) : hold1;

  // Start permission: free-running, or own turn with the other channel idle
  assign start_c[0] = en && (!mode || (!turn_q && (st_q[1] == S_IDLE)));
  assign start_c[1] = en && (!mode || ( turn_q && (st_q[0] == S_IDLE)));

  // Two-flop synchroniser for the asynchronous grants
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gsync_q <= '0;
      gs_q    <= '0;
    end else begin
      gsync_q <= {mx.grant1, mx.grant0};
      gs_q    <= gsync_q;
    end
  end

  // Next-state, counters, registered-output inputs and error capture
  always_comb begin
    dly_d  = dly_q;
    tmr_d  = '0;
    req_d  = '0;
    done_d = '0;
    spur_c = '0;
    tmo_c  = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        S_IDLE: begin
          spur_c[i] = gs_q[i];
          if (start_c[i]) begin
            st_d[i] = S_REQ;
          end
        end
        S_REQ: begin
          if (gs_q[i]) begin
            st_d[i]  = S_HOLD;
            dly_d[i] = hold_sel[i];
          end else if (tmr_q[i] == TMR_W'(TMO)) begin
            tmo_c[i] = 1'b1;
            st_d[i]  = S_IDLE;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (dly_q[i] <= HOLD_W'(1)) begin
            st_d[i] = S_REL;
          end else begin
            dly_d[i] = dly_q[i] - HOLD_W'(1);
          end
        end
        S_REL: begin
          if (!gs_q[i]) begin
            done_d[i] = 1'b1;
            dly_d[i]  = gap;
            st_d[i]   = S_GAP;
          end else if (tmr_q[i] == TMR_W'(TMO)) begin
            tmo_c[i] = 1'b1;
            st_d[i]  = S_IDLE;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
        end
        S_GAP: begin
          spur_c[i] = gs_q[i];
          if (dly_q[i] == '0) begin
            st_d[i] = S_IDLE;
          end else begin
            dly_d[i] = dly_q[i] - HOLD_W'(1);
          end
        end
        default: begin
          st_d[i] = S_IDLE;
        end
      endcase
      req_d[i] = (st_d[i] == S_REQ) || (st_d[i] == S_HOLD);
    end

    turn_d = turn_q ^ done_d[0] ^ done_d[1];

    // One cycle of both grants is synchroniser skew; two is a real overlap
    ovl_c  = gs_q[0] & gs_q[1];
    err_d  = err_q;
    code_d = code_q;
    if (!err_q) begin
      if (ovl_c && ovl_q) begin
        err_d  = 1'b1;
        code_d = E_OVL;
      end else if (|spur_c) begin
        err_d  = 1'b1;
        code_d = E_SPUR;
      end else if (|tmo_c) begin
        err_d  = 1'b1;
        code_d = E_TMO;
      end
    end
  end

  // State and registered outputs; reset drops req immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q[0] <= S_IDLE;
      st_q[1] <= S_IDLE;
      dly_q   <= '0;
      tmr_q   <= '0;
      req_q   <= '0;
      done_q  <= '0;
      turn_q  <= 1'b0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      dly_q   <= dly_d;
      tmr_q   <= tmr_d;
      req_q   <= req_d;
      done_q  <= done_d;
      turn_q  <= turn_d;
      ovl_q   <= ovl_c;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign mx.req0  = req_q[0];
  assign mx.req1  = req_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign err      = err_q;
  assign err_code = code_q;

`ifdef MUTEX_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Completed-handshake counters, updated alongside the done pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (done_d[0]) begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (done_d[1]) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mutex_sched.sv
// Directed self-checking bench for mutex_sched with a 3-cycle mutex model.
`timescale 1ns/1ps
module tb_mutex_sched;

`ifdef MUTEX_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [7:0]  hold0;
  logic [7:0]  hold1;
  logic [7:0]  gap;
  logic        done0;
  logic        done1;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  logic        inj0 = 1'b0;
  logic        inj1 = 1'b0;
  logic        blk0 = 1'b0;
  logic        mg0;
  logic        mg1;
  logic        prio;
  logic [1:0]  d1;
  logic [1:0]  d2;

  int n_checks = 0;
  int n_errs   = 0;
  int n_done0  = 0;
  int n_done1  = 0;
  int alt_bad  = 0;
  int both_req = 0;
  int ovl2     = 0;
  logic last_ch   = 1'b0;
  logic seen_done = 1'b0;
  logic prev_ovl  = 1'b0;

  int b0;
  int b1;
  int ba;
  int bb;
  int bo;
  int dd0;
  int dd1;
  int t1;

  mutex_sched_if mx ();
  assign mx.grant0 = mg0 | inj0;
  assign mx.grant1 = mg1 | inj1;

  mutex_sched #(
    .HOLD_W(8),
    .TMO   (1023),
    .CNT_W (16)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .en      (en),
    .mode    (mode),
    .hold0   (hold0),
    .hold1   (hold1),
    .gap     (gap),
    .mx      (mx),
    .done0   (done0),
    .done1   (done1),
    .err     (err),
    .err_code(err_code),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  always #5 clk = ~clk;

  // Mutex model: requests seen through a 2-stage pipe, grant registered (3 cycles)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1   <= 2'b00;
      d2   <= 2'b00;
      mg0  <= 1'b0;
      mg1  <= 1'b0;
      prio <= 1'b0;
    end else begin
      d1 <= {mx.req1, mx.req0};
      d2 <= d1;
      if (mg0) begin
        mg0 <= d2[0];
      end else if (mg1) begin
        mg1 <= d2[1];
      end else if (d2[0] && !blk0 && (!d2[1] || !prio)) begin
        mg0  <= 1'b1;
        prio <= 1'b1;
      end else if (d2[1]) begin
        mg1  <= 1'b1;
        prio <= 1'b0;
      end
    end
  end

  // Monitor: done counts, alternation, concurrent requests, grant overlap
  always @(negedge clk) begin
    if (done0) n_done0++;
    if (done1) n_done1++;
    if (done0 || done1) begin
      if (mode && seen_done && (done1 == last_ch)) alt_bad++;
      last_ch   = done1;
      seen_done = 1'b1;
    end
    if (mode && mx.req0 && mx.req1) both_req++;
    if (mx.grant0 && mx.grant1 && prev_ovl) ovl2++;
    prev_ovl = mx.grant0 && mx.grant1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (((n_done0 + n_done1) < target) && (c < budget)) begin
      step(1);
      c++;
    end
    chk(tag, 32'((n_done0 + n_done1) >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    inj0  = 1'b0;
    inj1  = 1'b0;
    blk0  = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    hold0 = 8'd0;
    hold1 = 8'd0;
    gap   = 8'd0;
    step(2);

    // Reset state
    chk("rst_req0", 32'(mx.req0), 32'd0);
    chk("rst_req1", 32'(mx.req1), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Scenario 1: round-robin, exact first-handshake timing then 10 handshakes
    mode  = 1'b1;
    hold0 = 8'd4;
    hold1 = 8'd6;
    gap   = 8'd2;
    b0 = n_done0;
    b1 = n_done1;
    ba = alt_bad;
    bb = both_req;
    en = 1'b1;
    step(1);
    chk("s1_req0_rise", 32'(mx.req0), 32'd1);
    chk("s1_req1_wait", 32'(mx.req1), 32'd0);
    step(9);
    chk("s1_req0_last_hold", 32'(mx.req0), 32'd1);
    step(1);
    chk("s1_req0_drop", 32'(mx.req0), 32'd0);
    step(5);
    chk("s1_done0_early", 32'(done0), 32'd0);
    step(1);
    chk("s1_done0_pulse", 32'(done0), 32'd1);
    step(1);
    chk("s1_done0_width", 32'(done0), 32'd0);
    step(2);
    chk("s1_req1_gap", 32'(mx.req1), 32'd0);
    step(1);
    chk("s1_req1_rise", 32'(mx.req1), 32'd1);
    wait_dones(b0 + b1 + 10, 3000, "s1_ten_done");
    en = 1'b0;
    step(80);
    chk("s1_done0_cnt", 32'(n_done0 - b0), 32'd5);
    chk("s1_done1_cnt", 32'(n_done1 - b1), 32'd5);
    chk("s1_alternate", 32'(alt_bad - ba), 32'd0);
    chk("s1_one_in_flight", 32'(both_req - bb), 32'd0);
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_cnt0", 32'(cnt0), STATS ? 32'd5 : 32'd0);
    chk("s1_cnt1", 32'(cnt1), STATS ? 32'd5 : 32'd0);

    // Scenario 2: free-running contention for 100 handshakes
    do_reset();
    mode  = 1'b0;
    hold0 = 8'd3;
    hold1 = 8'd5;
    gap   = 8'd1;
    b0 = n_done0;
    b1 = n_done1;
    bo = ovl2;
    en = 1'b1;
    wait_dones(b0 + b1 + 100, 20000, "s2_hundred_done");
    en = 1'b0;
    step(80);
    dd0 = n_done0 - b0;
    dd1 = n_done1 - b1;
    chk("s2_err", 32'(err), 32'd0);
    chk("s2_no_overlap", 32'(ovl2 - bo), 32'd0);
    chk("s2_both_progress", 32'((dd0 > 0) && (dd1 > 0)), 32'd1);
    chk("s2_cnt_sum", 32'(cnt0) + 32'(cnt1), STATS ? 32'(dd0 + dd1) : 32'd0);
    chk("s2_cnt0", 32'(cnt0), STATS ? 32'(dd0) : 32'd0);

    // Scenario 3: injected grant1 while grant0 held
    do_reset();
    mode  = 1'b0;
    hold0 = 8'd20;
    hold1 = 8'd2;
    gap   = 8'd2;
    en = 1'b1;
    step(1);
    chk("s3_req0_together", 32'(mx.req0), 32'd1);
    chk("s3_req1_together", 32'(mx.req1), 32'd1);
    step(3);
    inj1 = 1'b1;
    step(1);
    inj1 = 1'b0;
    step(10);
    chk("s3_skew_tolerated", 32'(err), 32'd0);
    chk("s3_req1_again", 32'(mx.req1), 32'd1);
    inj1 = 1'b1;
    step(3);
    inj1 = 1'b0;
    chk("s3_err_not_yet", 32'(err), 32'd0);
    step(1);
    chk("s3_err_set", 32'(err), 32'd1);
    chk("s3_code_ovl", 32'(err_code), 32'd1);
    en = 1'b0;
    step(80);
    inj0 = 1'b1;
    step(3);
    inj0 = 1'b0;
    step(5);
    chk("s3_err_sticky", 32'(err), 32'd1);
    chk("s3_code_kept", 32'(err_code), 32'd1);

    // Scenario 4: channel 0 never granted
    do_reset();
    mode  = 1'b0;
    hold0 = 8'd2;
    hold1 = 8'd3;
    gap   = 8'd1;
    blk0  = 1'b1;
    b0 = n_done0;
    en = 1'b1;
    step(1);
    chk("s4_req0_rise", 32'(mx.req0), 32'd1);
    step(1023);
    chk("s4_no_err_1023", 32'(err), 32'd0);
    chk("s4_req0_held", 32'(mx.req0), 32'd1);
    step(1);
    chk("s4_err_set", 32'(err), 32'd1);
    chk("s4_code_tmo", 32'(err_code), 32'd3);
    chk("s4_req0_dropped", 32'(mx.req0), 32'd0);
    t1 = n_done1;
    step(200);
    chk("s4_no_done0", 32'(n_done0 - b0), 32'd0);
    chk("s4_ch1_continues", 32'(n_done1 > t1), 32'd1);
    en   = 1'b0;
    blk0 = 1'b0;

    // Scenario 5: reset during channel 0 HOLD
    do_reset();
    mode  = 1'b1;
    hold0 = 8'd10;
    hold1 = 8'd2;
    gap   = 8'd2;
    en = 1'b1;
    step(9);
    chk("s5_req0_in_hold", 32'(mx.req0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s5_req0_async", 32'(mx.req0), 32'd0);
    chk("s5_req1", 32'(mx.req1), 32'd0);
    chk("s5_done0", 32'(done0), 32'd0);
    chk("s5_err", 32'(err), 32'd0);
    chk("s5_code", 32'(err_code), 32'd0);
    chk("s5_cnt0", 32'(cnt0), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("s5_restart_req0", 32'(mx.req0), 32'd1);
    b0 = n_done0;
    for (int c = 0; (c < 300) && (n_done0 == b0); c++) begin
      step(1);
    end
    chk("s5_restart_done", 32'(n_done0 - b0), 32'd1);
    chk("s5_err_after", 32'(err), 32'd0);
    en = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mutex_sched.md
# mutex_sched

Synchronous scheduler that exercises and polices a two-way asynchronous mutex. It drives `req0`/`req1` with four-phase handshakes: raise request, wait for grant, hold for a programmed number of cycles, drop request, wait for grant release. It synchronises the asynchronous grants and flags mutual-exclusion and protocol violations. It sits in the test top between the clock buffer and the mutex, replacing the free-running request generator with a programmable, self-checking one.

## Interface
Parameters:
- `HOLD_W`, 8: width of hold/gap cycle counts.
- `TMO`, 1023: max cycles waiting for a grant edge before timeout.
- `CNT_W`, 16: width of statistics counters.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: when high, channels may start new handshakes.
- `mode` in 1: 0 = both channels free-running (contention); 1 = alternate, one channel in flight at a time, round-robin.
- `hold0`, `hold1` in HOLD_W: cycles to keep the request after the grant is seen (0 is treated as 1).
- `gap` in HOLD_W: idle cycles after release before a channel may re-request.
- `grant0`, `grant1` in 1: asynchronous grants from the mutex.
- `req0`, `req1` out 1: registered requests to the mutex.
- `done0`, `done1` out 1: one-cycle pulse when a handshake completes (release seen).
- `err` out 1: sticky error flag.
- `err_code` out 2: first error captured; 01 overlap, 10 spurious grant, 11 timeout.
- `cnt0`, `cnt1` out CNT_W: completed handshakes per channel (stats build only).

## Operation
- Each grant passes through a 2-FF synchroniser, giving `g0s`/`g1s`.
- Per-channel FSM states and transitions:
  - IDLE: if `en`, and either `mode`=0 or it is this channel's turn, go to REQ.
  - REQ: `req`=1. When `gNs`=1, load the hold counter and go to HOLD.
  - HOLD: count down; at 1, go to REL.
  - REL: `req`=0. When `gNs`=0, pulse `doneN`, load the gap counter and go to GAP.
  - GAP: count down to 0, then go to IDLE.
- Round-robin in `mode`=1:
  - The turn pointer toggles on each `done`.
  - Reset value points to channel 0.
  - A channel is "in flight" from REQ until GAP exit.
- Deasserting `en` stops new REQ entries only. In-flight handshakes always complete.
- Error detection (sets `err` and captures `err_code` only if `err`=0):
  - Overlap: `g0s` and `g1s` both 1 for 2 consecutive cycles. A single-cycle overlap is tolerated as synchroniser skew.
  - Spurious: `gNs`=1 while channel N is in IDLE or GAP.
  - Timeout: more than `TMO` consecutive cycles in REQ or REL.
- Channel behaviour after an error:
  - A timed-out channel drops `req` and returns to IDLE with no `done`.
  - Other channels continue.
  - The error clears only on reset.
- If both channels enter REQ in the same cycle (`mode`=0), both requests assert together. Arbitration is the mutex's job.

## Timing
- All outputs and state are 0 / IDLE during and immediately after reset. The turn pointer is 0.
- `req` asserts on the cycle after IDLE→REQ is decided (registered output).
- Grant rise to HOLD entry is 2 cycles of synchroniser latency plus 1 cycle of state update.
- `req` stays high for `hold`+1 cycles after the cycle `gNs` is first seen high.
- `done` pulses in the cycle after `gNs` is seen low in REL.
- Minimum handshake period is about `hold` + `gap` + 8 cycles for a zero-delay mutex.
- `cnt0`/`cnt1` increment in the same cycle as `doneN` and wrap modulo 2^CNT_W.
- If reset asserts mid-handshake, `req` drops asynchronously. The mutex then releases on its own.

## Configuration
- `MUTEX_SCHED_STATS_EN`:
  - Defined: `cnt0`/`cnt1` are live counters.
  - Undefined: the counter registers are removed and `cnt0`/`cnt1` are tied to 0.
  - FSM and error logic are identical in both builds.

## Test plan
- Mutex model with 3-cycle grant delay, `mode`=1, `hold0`=4, `hold1`=6, `gap`=2, `en`=1 for 10 handshakes -> `req0`/`req1` alternate, 5 `done` pulses each, `cnt0`=`cnt1`=5, `err`=0.
- `mode`=0 with both channels contending for 100 handshakes -> never 2 cycles of overlap, `err`=0, `cnt0`+`cnt1` matches the total `done` pulses.
- Faulty model that raises `grant1` while `grant0` is held for 3 cycles -> `err`=1, `err_code`=01; a later fault does not change `err_code`.
- Model that never grants channel 0, `TMO`=1023 -> `err_code`=11 at cycle 1024 of REQ, `req0` drops, channel 1 keeps completing.
- Reset pulsed low while channel 0 is in HOLD -> `req0`=0 immediately, all outputs 0, and channel 0 restarts from IDLE after reset is released.
- Build without `MUTEX_SCHED_STATS_EN` -> `cnt0`=`cnt1`=0 throughout scenario 1, same `done`/`err` behaviour.
